packet_stream_assembler: RTL and testbench

- Parametrised successor to the per-packet HDMI data island assembler.
- Accepts whole packets (24-bit header plus four 56-bit subpackets) through a valid/ready handshake into an internal packet FIFO.
- During a data island, serialises back-to-back 32-pixel packets onto the 9-bit TERC4 payload (bit 0 to channel 0 bit 2; bits 4:1 and 8:5 to channels 1/2), computing the BCH ECC on the fly.
- Inserts null packets on underrun, aborts cleanly if the island ends mid-packet, and tracks the IEC 60958 frame count for audio packets.

---
 rtl/packet_stream_assembler.sv | 150 +++++++++++++++
 tb/tb_packet_stream_assembler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_stream_assembler.sv
// rtl/packet_stream_assembler.sv - buffered HDMI data island packet serialiser with on-the-fly BCH ECC
module packet_stream_assembler #(
  parameter int         FIFO_DEPTH        = 4,
  parameter int         MAX_PACKETS       = 18,
  parameter logic [7:0] AUDIO_PACKET_TYPE = 8'h02,
  parameter int         FRAME_MODULUS     = 192
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [23:0]  in_header,
  input  logic [223:0] in_sub,
  input  logic         data_island_period,
  output logic [8:0]   packet_data,
  output logic         packet_start,
  output logic [4:0]   packet_index,
  output logic [7:0]   frame_counter,
  output logic [15:0]  underrun_count,
  output logic         abort
);

  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    return (ecc[0] ^ b) ? ((ecc >> 1) ^ 8'h83) : (ecc >> 1);
  endfunction

  logic [23:0]   hdr_mem [FIFO_DEPTH];
  logic [223:0]  sub_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [4:0]    c;
  logic [4:0]    slot_next;
  logic          slot_start, slot_ok;
  logic [23:0]   cur_hdr;
  logic [223:0]  cur_sub;
  logic          cur_real;
  logic [7:0]    ecc4_q;
  logic [7:0]    ecc_q [4];

  logic [23:0]   pkt_hdr;
  logic [223:0]  pkt_sub;
  logic [7:0]    ecc4_base, ecc4_nxt;
  logic [31:0]   blk4;
  logic [7:0]    ecc_base [4];
  logic [7:0]    ecc_nxt [4];
  logic [63:0]   blk [4];
  logic [5:0]    bit_e, bit_o;
  logic [8:0]    word;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign slot_start = data_island_period && (c == 5'd0);
  assign slot_ok    = (32'(slot_next) < MAX_PACKETS);
  assign pop        = slot_start && slot_ok && !empty;
  assign bit_e      = {c, 1'b0};
  assign bit_o      = {c, 1'b1};

  // Pixel 0 reads the FIFO head directly so the first word needs no extra latency.
  always_comb begin
    pkt_hdr = cur_hdr;
    pkt_sub = cur_sub;
    if (slot_start) begin
      pkt_hdr = pop ? hdr_mem[rd_ptr] : '0;
      pkt_sub = pop ? sub_mem[rd_ptr] : '0;
    end
    ecc4_base = (c == 5'd0) ? 8'd0 : ecc4_q;
    blk4      = {ecc4_base, pkt_hdr};
    ecc4_nxt  = (c < 5'd24) ? bch_step(ecc4_base, blk4[c]) : ecc4_base;
    for (int i = 0; i < 4; i++) begin
      ecc_base[i] = (c == 5'd0) ? 8'd0 : ecc_q[i];
      blk[i]      = {ecc_base[i], pkt_sub[56*i +: 56]};
      ecc_nxt[i]  = (c < 5'd28) ? bch_step(bch_step(ecc_base[i], blk[i][bit_e]), blk[i][bit_o])
                                : ecc_base[i];
    end
    word = {blk[3][bit_o], blk[2][bit_o], blk[1][bit_o], blk[0][bit_o],
            blk[3][bit_e], blk[2][bit_e], blk[1][bit_e], blk[0][bit_e],
            blk4[c]};
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      hdr_mem[wr_ptr] <= in_header;
      sub_mem[wr_ptr] <= in_sub;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      c              <= '0;
      slot_next      <= '0;
      cur_hdr        <= '0;
      cur_sub        <= '0;
      cur_real       <= 1'b0;
      ecc4_q         <= '0;
      for (int i = 0; i < 4; i++) ecc_q[i] <= '0;
      packet_data    <= '0;
      packet_start   <= 1'b0;
      packet_index   <= '0;
      frame_counter  <= '0;
      underrun_count <= '0;
      abort          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      abort <= 1'b0;

      if (data_island_period) begin
        c            <= c + 5'd1;
        packet_data  <= word;
        packet_start <= (c == 5'd0);
        ecc4_q       <= ecc4_nxt;
        for (int i = 0; i < 4; i++) ecc_q[i] <= ecc_nxt[i];
        if (c == 5'd0) begin
          cur_hdr      <= pkt_hdr;
          cur_sub      <= pkt_sub;
          cur_real     <= pop;
          packet_index <= slot_next;
          slot_next    <= (slot_next == 5'd31) ? 5'd31 : slot_next + 5'd1;
          if (slot_ok && empty && (underrun_count != 16'hFFFF))
            underrun_count <= underrun_count + 16'd1;
        end
        if ((c == 5'd31) && cur_real && (cur_hdr[7:0] == AUDIO_PACKET_TYPE))
          frame_counter <= (32'(frame_counter) == FRAME_MODULUS - 1) ? 8'd0 : frame_counter + 8'd1;
      end else begin
        packet_data  <= '0;
        packet_start <= 1'b0;
        slot_next    <= '0;
        // Island ended mid-packet: drop the remainder and restart clean.
        if (c != 5'd0) begin
          abort  <= 1'b1;
          c      <= '0;
          ecc4_q <= '0;
          for (int i = 0; i < 4; i++) ecc_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_stream_assembler.sv
// tb/tb_packet_stream_assembler.sv - randomized bench for packet_stream_assembler against a packet-level model
module tb_packet_stream_assembler;

  localparam int         DEPTH = 4;
  localparam int         MAX_P = 3;
  localparam logic [7:0] AUD   = 8'h02;
  localparam int         FMOD  = 192;

  logic         clk_pixel;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [23:0]  in_header;
  logic [223:0] in_sub;
  logic         data_island_period;
  logic [8:0]   packet_data;
  logic         packet_start;
  logic [4:0]   packet_index;
  logic [7:0]   frame_counter;
  logic [15:0]  underrun_count;
  logic         abort;

  packet_stream_assembler #(
    .FIFO_DEPTH(DEPTH), .MAX_PACKETS(MAX_P), .AUDIO_PACKET_TYPE(AUD), .FRAME_MODULUS(FMOD)
  ) dut (
    .clk_pixel(clk_pixel), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_header(in_header), .in_sub(in_sub), .data_island_period(data_island_period),
    .packet_data(packet_data), .packet_start(packet_start), .packet_index(packet_index),
    .frame_counter(frame_counter), .underrun_count(underrun_count), .abort(abort)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [23:0]  q_hdr [$];
  logic [223:0] q_sub [$];
  int           mc, mslot, midx, mframe, munder;
  logic [23:0]  mcur_hdr;
  logic [223:0] mcur_sub;
  bit           mcur_real;
  logic [8:0]   words  [32];
  logic [8:0]   obs_pd [32];

  function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
    logic [7:0] e;
    e = 8'd0;
    for (int i = 0; i < n; i++) e = (e[0] ^ bits[i]) ? ((e >> 1) ^ 8'h83) : (e >> 1);
    return e;
  endfunction

  function automatic void build_words(input logic [23:0] h, input logic [223:0] s);
    logic [31:0] b4;
    logic [63:0] b [4];
    b4 = {bch({40'd0, h}, 24), h};
    for (int i = 0; i < 4; i++) b[i] = {bch({8'd0, s[56*i +: 56]}, 56), s[56*i +: 56]};
    for (int k = 0; k < 32; k++)
      words[k] = {b[3][2*k+1], b[2][2*k+1], b[1][2*k+1], b[0][2*k+1],
                  b[3][2*k],   b[2][2*k],   b[1][2*k],   b[0][2*k], b4[k]};
  endfunction

  function automatic logic [23:0] rnd_hdr(input bit audio);
    logic [23:0] h;
    h = 24'($urandom);
    if (audio) h[7:0] = AUD;
    else if (h[7:0] == AUD) h[7:0] = 8'h84;
    return h;
  endfunction

  function automatic logic [223:0] rnd_sub();
    logic [223:0] s;
    for (int k = 0; k < 7; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  task automatic cycle(input bit dip, input bit vld, input logic [23:0] h, input logic [223:0] s);
    bit         rdy_exp, acc, e_st, e_ab;
    logic [8:0] e_pd;
    int         c_now;
    data_island_period = dip;
    in_valid  = vld;
    in_header = h;
    in_sub    = s;
    rdy_exp = (q_hdr.size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    acc   = vld && rdy_exp;
    c_now = mc;
    e_ab  = 1'b0;
    if (dip) begin
      if (mc == 0) begin
        if (mslot < MAX_P && q_hdr.size() > 0) begin
          mcur_hdr  = q_hdr.pop_front();
          mcur_sub  = q_sub.pop_front();
          mcur_real = 1'b1;
        end else begin
          mcur_hdr  = '0;
          mcur_sub  = '0;
          mcur_real = 1'b0;
          if (mslot < MAX_P && munder < 65535) munder++;
        end
        build_words(mcur_hdr, mcur_sub);
        midx  = mslot;
        mslot = (mslot < 31) ? mslot + 1 : 31;
      end
      e_pd = words[mc];
      e_st = (mc == 0);
      if (mc == 31 && mcur_real && mcur_hdr[7:0] == AUD) mframe = (mframe + 1) % FMOD;
      mc = (mc + 1) % 32;
    end else begin
      e_pd  = '0;
      e_st  = 1'b0;
      e_ab  = (mc != 0);
      mc    = 0;
      mslot = 0;
    end
    if (acc) begin
      q_hdr.push_back(h);
      q_sub.push_back(s);
    end
    @(posedge clk_pixel);
    #1;
    if (dip) obs_pd[c_now] = packet_data;
    check("packet_data",    32'(packet_data),    32'(e_pd));
    check("packet_start",   32'(packet_start),   32'(e_st));
    check("packet_index",   32'(packet_index),   32'(midx));
    check("abort",          32'(abort),          32'(e_ab));
    check("frame_counter",  32'(frame_counter),  32'(mframe));
    check("underrun_count", 32'(underrun_count), 32'(munder));
    in_valid = 1'b0;
  endtask

  task automatic push_pkt(input logic [23:0] h, input logic [223:0] s);
    cycle(1'b0, 1'b1, h, s);
  endtask

  task automatic island(input int npix, input bit rnd_push);
    for (int p = 0; p < npix; p++)
      cycle(1'b1, rnd_push && ($urandom_range(0, 3) == 0), rnd_hdr($urandom_range(0, 1) == 1), rnd_sub());
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0);
  endtask

  logic [7:0] ecc_obs;

  initial begin
    reset = 1'b1;
    data_island_period = 1'b0;
    in_valid = 1'b0;
    in_header = '0;
    in_sub = '0;
    mc = 0; mslot = 0; midx = 0; mframe = 0; munder = 0;
    mcur_hdr = '0; mcur_sub = '0; mcur_real = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_packet_data", 32'(packet_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_packet_start", 32'(packet_start), 32'd0);
    check("rst_packet_index", 32'(packet_index), 32'd0);
    check("rst_frame", 32'(frame_counter), 32'd0);
    check("rst_underrun", 32'(underrun_count), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    reset = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, '0, '0);

    push_pkt(24'h000001, '0);
    island(32, 1'b0);
    for (int k = 0; k < 8; k++) ecc_obs[k] = obs_pd[24+k][0];
    check("hdr1_ecc", 32'(ecc_obs), 32'h4A);
    check("hdr1_pix0", 32'(obs_pd[0]), 32'h001);

    island(96, 1'b0);
    check("empty_underrun", 32'(underrun_count), 32'd3);
    check("empty_frame", 32'(frame_counter), 32'd0);

    for (int k = 0; k < 4; k++) push_pkt(rnd_hdr(1'b1), rnd_sub());
    check("full_in_ready", 32'(in_ready), 32'd0);
    island(128, 1'b0);
    check("max_frame", 32'(frame_counter), 32'd3);
    check("max_underrun", 32'(underrun_count), 32'd3);
    check("max_fifo_left", 32'(in_ready), 32'd1);
    island(32, 1'b0);
    check("audio4_frame", 32'(frame_counter), 32'd4);

    push_pkt(rnd_hdr(1'b0), rnd_sub());
    push_pkt(rnd_hdr(1'b0), rnd_sub());
    island(10, 1'b0);
    island(32, 1'b0);
    check("abort_frame", 32'(frame_counter), 32'd4);

    for (int it = 0; it < 62; it++) begin
      for (int k = 0; k < 3; k++) push_pkt(rnd_hdr(1'b1), rnd_sub());
      island(96, 1'b0);
    end
    check("frame190", 32'(frame_counter), 32'd190);
    push_pkt(rnd_hdr(1'b1), rnd_sub());
    island(32, 1'b0);
    check("frame191", 32'(frame_counter), 32'd191);
    push_pkt(rnd_hdr(1'b1), rnd_sub());
    island(32, 1'b0);
    check("frame_wrap", 32'(frame_counter), 32'd0);

    for (int it = 0; it < 40; it++) begin
      int npush;
      npush = $urandom_range(0, 4);
      for (int k = 0; k < npush; k++) push_pkt(rnd_hdr($urandom_range(0, 1) == 1), rnd_sub());
      island($urandom_range(1, 100), 1'b1);
    end

    push_pkt(rnd_hdr(1'b1), rnd_sub());
    push_pkt(rnd_hdr(1'b1), rnd_sub());
    for (int p = 0; p < 17; p++) cycle(1'b1, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    check("midrst_packet_data", 32'(packet_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_packet_start", 32'(packet_start), 32'd0);
    check("midrst_packet_index", 32'(packet_index), 32'd0);
    check("midrst_frame", 32'(frame_counter), 32'd0);
    check("midrst_underrun", 32'(underrun_count), 32'd0);
    check("midrst_abort", 32'(abort), 32'd0);
    data_island_period = 1'b0;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    q_hdr.delete();
    q_sub.delete();
    mc = 0; mslot = 0; midx = 0; mframe = 0; munder = 0;
    mcur_hdr = '0; mcur_sub = '0; mcur_real = 1'b0;
    island(32, 1'b0);
    check("postrst_underrun", 32'(underrun_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
